johnson_counter_5bit: RTL and testbench

5-bit Johnson (twisted-ring) counter with clock enable. It steps through a fixed 10-state sequence, one state per enabled clock, and wraps. It serves as a low-glitch sequence or phase generator: adjacent states differ in exactly one bit, and any state decodes with a 2-input gate. It sits in a single clock domain and is driven by local control logic.

---
 rtl/johnson_counter_5bit.sv | 56 +++++
 tb/tb_johnson_counter_5bit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/johnson_counter_5bit.sv
`default_nettype none
// ============================================================================
// Module   : johnson_counter_5bit
// Brief    : 5-bit Johnson (twisted-ring) counter with clock enable.
//            Walks a 10-state sequence in which neighbouring states differ in
//            one bit. Asynchronous active-low reset to 00000.
//            Optional build macro JOHNSON_SELF_CORRECT_EN: an enabled edge
//            taken from any of the 22 unreachable codes loads 00000 instead
//            of shifting.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_counter_5bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic [4:0] q
);

   localparam logic [4:0] c_RESET_STATE = 5'b00000;

   logic [4:0] w_next_q;

`ifdef JOHNSON_SELF_CORRECT_EN
   // A legal Johnson code has at most one bit-to-bit change across q[4:0],
   // read as a straight (non-circular) word.
   logic [3:0] w_transitions;
   logic       w_legal;

   assign w_transitions = q[4:1] ^ q[3:0];
   assign w_legal       = ((w_transitions & (w_transitions - 4'd1)) == 4'd0);

   // Next state: twisted shift for legal codes, back to the start otherwise.
   always_comb begin
      w_next_q = {q[3:0], ~q[4]};
      if (!w_legal) begin
         w_next_q = c_RESET_STATE;
      end
   end
`else
   // Next state: shift left, feeding the inverted MSB into the LSB.
   always_comb begin
      w_next_q = {q[3:0], ~q[4]};
   end
`endif

   // State register: async clear, advance only on enabled edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= c_RESET_STATE;
      end else if (enable) begin
         q <= w_next_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter_5bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_counter_5bit
// Brief    : Scoreboard bench for johnson_counter_5bit. Stimulus pushes the
//            hand-computed expected state and raises a sample event; a
//            separate monitor pops and compares against q.
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_counter_5bit;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [4:0] q;

   typedef struct {
      logic [4:0] exp;
      string      name;
   } exp_t;

   exp_t queue_exp[$];
   event sample_ev;
   int   compared   = 0;
   int   mismatched = 0;

   johnson_counter_5bit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .q      (q)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: drains the scoreboard whenever stimulus signals a sample point.
   initial begin
      forever begin
         @(sample_ev);
         while (queue_exp.size() > 0) begin
            exp_t e;
            e = queue_exp.pop_front();
            compared++;
            if (q !== e.exp) begin
               mismatched++;
               $display("FAIL %s: q=%b expected=%b at %0t", e.name, q, e.exp, $time);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic expect_q(input logic [4:0] exp, input string name);
      exp_t e;
      e.exp  = exp;
      e.name = name;
      queue_exp.push_back(e);
      ->sample_ev;
      #1;
   endtask

   // One rising edge, then sample 1 ns later.
   task automatic edge_check(input logic [4:0] exp, input string name);
      @(posedge clk);
      #1;
      expect_q(exp, name);
   endtask

   logic [4:0] seq [10];

   initial begin
      seq[0] = 5'b00000; seq[1] = 5'b00001; seq[2] = 5'b00011;
      seq[3] = 5'b00111; seq[4] = 5'b01111; seq[5] = 5'b11111;
      seq[6] = 5'b11110; seq[7] = 5'b11100; seq[8] = 5'b11000;
      seq[9] = 5'b10000;

      rst_n  = 1'b1;
      enable = 1'b0;

      // Reset asserted between edges, held 20 ns across clock edges.
      #2 rst_n = 1'b0;
      #1 expect_q(5'b00000, "reset_immediate");
      #16 expect_q(5'b00000, "reset_held");

      // Release away from a rising edge, enable low: state holds.
      @(negedge clk);
      rst_n = 1'b1;
      edge_check(5'b00000, "hold_after_reset");

      // Two full periods minus one edge: 19 enabled edges.
      @(negedge clk);
      enable = 1'b1;
      for (int i = 1; i <= 19; i++) begin
         edge_check(seq[i % 10], (i == 10) ? "wrap_edge10" : $sformatf("seq_edge%0d", i));
      end

      // q is 10000 here; async reset mid-count, between edges.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 expect_q(5'b00000, "async_reset_midcount");
      #17;
      @(negedge clk);
      rst_n = 1'b1;
      edge_check(5'b00001, "resume_after_reset");

      // Enable low holds a non-zero state.
      @(negedge clk);
      enable = 1'b0;
      edge_check(5'b00001, "hold_enable_low_a");
      edge_check(5'b00001, "hold_enable_low_b");

      // Illegal code injection.
      @(negedge clk);
      force dut.q = 5'b01010;
      #1 release dut.q;
      #1 expect_q(5'b01010, "illegal_hold_after_release");
      edge_check(5'b01010, "illegal_hold_enable_low");
      @(negedge clk);
      enable = 1'b1;
`ifdef JOHNSON_SELF_CORRECT_EN
      edge_check(5'b00000, "self_correct_edge1");
      edge_check(5'b00001, "self_correct_edge2");
`else
      edge_check(5'b10101, "parasitic_edge1");
      edge_check(5'b01010, "parasitic_edge2");
`endif

      // Reset coincident with an enabled rising edge: reset wins.
      @(posedge clk);
      rst_n = 1'b0;
      #1 expect_q(5'b00000, "reset_at_edge");
      @(negedge clk);
      rst_n = 1'b1;
      edge_check(5'b00001, "after_coincident_reset");

      #5;
      if (queue_exp.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", queue_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
